// File: rtl/sram_axi_bridge_if.sv
// Signal bundle between the CPU SRAM-like ports, the bridge and the AXI fabric.
// master = bridge view; slave = the CPU/AXI environment driving the bridge.
interface sram_axi_bridge_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic [31:0] inst_sram_addr_ok_addr;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_sram_req, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_addr_ok_addr, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
        input  data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output araddr, arsize, arvalid, rready,
        input  arready, rdata, rvalid,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bvalid
    );

    modport slave (
        output inst_sram_req, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_addr_ok_addr, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
        output data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  araddr, arsize, arvalid, rready,
        output arready, rdata, rvalid,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bvalid
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// SRAM-like inst/data ports to a single-outstanding AXI master; data port has fixed priority.
//
// state   | meaning
// IDLE    | accepting a new request (data before inst)
// RD_AR   | read address presented, waiting for arready
// RD_R    | waiting for read data, returned to the owner on rvalid
// WR_AW_W | write address and data presented, each drops after its own handshake
// WR_B    | waiting for the write response
module sram_axi_bridge (
    input  logic               clk,
    input  logic               reset,
    sram_axi_bridge_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_AR   = 3'd1,
        RD_R    = 3'd2,
        WR_AW_W = 3'd3,
        WR_B    = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        owner_data;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        accept_data, accept_inst;

    // Gating with reset keeps addr_ok low while reset is held, even in IDLE.
    assign accept_data = (state == IDLE) && !reset && bus.data_sram_req;
    assign accept_inst = (state == IDLE) && !reset && bus.inst_sram_req && !bus.data_sram_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= 2'd0;
            wstrb_q    <= 4'd0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_data) begin
                owner_data <= 1'b1;
                addr_q     <= bus.data_sram_addr;
                size_q     <= bus.data_sram_size;
                wstrb_q    <= bus.data_sram_wstrb;
                wdata_q    <= bus.data_sram_wdata;
            end else if (accept_inst) begin
                owner_data <= 1'b0;
                addr_q     <= bus.inst_sram_addr;
                size_q     <= 2'd2;
                wstrb_q    <= 4'd0;
                wdata_q    <= 32'd0;
            end
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WR_AW_W) begin
                if (bus.awready) aw_done <= 1'b1;
                if (bus.wready)  w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt                  = state;
        bus.inst_sram_addr_ok      = accept_inst;
        bus.inst_sram_addr_ok_addr = bus.inst_sram_addr;
        bus.data_sram_addr_ok      = accept_data;
        bus.inst_sram_data_ok      = 1'b0;
        bus.data_sram_data_ok      = 1'b0;
        bus.inst_sram_rdata        = bus.rdata;
        bus.data_sram_rdata        = bus.rdata;
        bus.araddr                 = addr_q;
        bus.arsize                 = {1'b0, size_q};
        bus.arvalid                = 1'b0;
        bus.rready                 = 1'b0;
        bus.awaddr                 = addr_q;
        bus.awsize                 = {1'b0, size_q};
        bus.awvalid                = 1'b0;
        bus.wdata                  = wdata_q;
        bus.wstrb                  = wstrb_q;
        bus.wvalid                 = 1'b0;
        bus.bready                 = 1'b0;

        case (state)
            IDLE: begin
                if (accept_data)
                    state_nxt = bus.data_sram_wr ? WR_AW_W : RD_AR;
                else if (accept_inst)
                    state_nxt = RD_AR;
            end
            RD_AR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) state_nxt = RD_R;
            end
            RD_R: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    bus.inst_sram_data_ok = !owner_data;
                    bus.data_sram_data_ok = owner_data;
                    state_nxt             = IDLE;
                end
            end
            WR_AW_W: begin
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
                if ((aw_done || bus.awready) && (w_done || bus.wready))
                    state_nxt = WR_B;
            end
            WR_B: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    bus.data_sram_data_ok = 1'b1;
                    state_nxt             = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed cycle-by-cycle checks of the SRAM-to-AXI bridge handshakes.
module tb_sram_axi_bridge;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [8:0] ctl;
    logic [8:0] exp;

    sram_axi_bridge_if bus();

    sram_axi_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {inst_addr_ok, data_addr_ok, arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}
    assign ctl = {bus.inst_sram_addr_ok, bus.data_sram_addr_ok, bus.arvalid, bus.rready,
                  bus.awvalid, bus.wvalid, bus.bready, bus.inst_sram_data_ok, bus.data_sram_data_ok};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h1234_5678;
        bus.data_sram_req  = 1'b1;
        #1;
        exp = 9'b000000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL reset_ctl got=%b want=%b", ctl, exp); end
        vectors++;
        if (bus.araddr !== 32'd0) begin miscompares++; $display("FAIL reset_araddr got=%h want=0", bus.araddr); end
        tick;
        bus.inst_sram_req = 1'b0;
        bus.data_sram_req = 1'b0;
        reset = 1'b0;
        #1;
        exp = 9'b000000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL reset_release got=%b want=%b", ctl, exp); end
    endtask

    task automatic test_inst_read;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'hBFC0_0000;
        bus.arready        = 1'b1;
        #1;
        exp = 9'b100000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL inst_rd_n got=%b want=%b", ctl, exp); end
        vectors++;
        if (bus.inst_sram_addr_ok_addr !== 32'hBFC0_0000) begin miscompares++; $display("FAIL inst_rd_okaddr got=%h want=bfc00000", bus.inst_sram_addr_ok_addr); end
        tick;
        bus.inst_sram_req = 1'b0;
        #1;
        exp = 9'b001000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL inst_rd_n1 got=%b want=%b", ctl, exp); end
        vectors++;
        if ({bus.araddr, bus.arsize} !== {32'hBFC0_0000, 3'd2}) begin miscompares++; $display("FAIL inst_rd_ar got=%h/%0d want=bfc00000/2", bus.araddr, bus.arsize); end
        tick;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h3C1D_0001;
        #1;
        exp = 9'b000100010; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL inst_rd_n2 got=%b want=%b", ctl, exp); end
        vectors++;
        if (bus.inst_sram_rdata !== 32'h3C1D_0001) begin miscompares++; $display("FAIL inst_rd_data got=%h want=3c1d0001", bus.inst_sram_rdata); end
        tick;
        bus.rvalid = 1'b0;
        #1;
        exp = 9'b000000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL inst_rd_idle got=%b want=%b", ctl, exp); end
    endtask

    task automatic test_priority;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h8000_2000;
        bus.data_sram_req  = 1'b1;
        bus.data_sram_wr   = 1'b0;
        bus.data_sram_size = 2'd2;
        bus.data_sram_addr = 32'h8000_1000;
        #1;
        exp = 9'b010000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL prio_accept got=%b want=%b", ctl, exp); end
        vectors++;
        if (bus.inst_sram_addr_ok_addr !== 32'h8000_2000) begin miscompares++; $display("FAIL prio_okaddr got=%h want=80002000", bus.inst_sram_addr_ok_addr); end
        tick;
        bus.data_sram_req = 1'b0;
        #1;
        exp = 9'b001000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL prio_ar got=%b want=%b", ctl, exp); end
        vectors++;
        if (bus.araddr !== 32'h8000_1000) begin miscompares++; $display("FAIL prio_araddr got=%h want=80001000", bus.araddr); end
        tick;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1122_3344;
        #1;
        exp = 9'b000100001; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL prio_data_ok got=%b want=%b", ctl, exp); end
        vectors++;
        if (bus.data_sram_rdata !== 32'h1122_3344) begin miscompares++; $display("FAIL prio_rdata got=%h want=11223344", bus.data_sram_rdata); end
        tick;
        bus.rvalid = 1'b0;
        #1;
        exp = 9'b100000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL prio_inst_accept got=%b want=%b", ctl, exp); end
        tick;
        bus.inst_sram_req = 1'b0;
        #1;
        vectors++;
        if ({ctl, bus.araddr} !== {9'b001000000, 32'h8000_2000}) begin miscompares++; $display("FAIL prio_inst_ar got=%b/%h want=001000000/80002000", ctl, bus.araddr); end
        tick;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0000_A5A5;
        #1;
        exp = 9'b000100010; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL prio_inst_ok got=%b want=%b", ctl, exp); end
        tick;
        bus.rvalid = 1'b0;
        #1;
    endtask

    task automatic test_byte_write;
        bus.awready         = 1'b0;
        bus.wready          = 1'b0;
        bus.data_sram_req   = 1'b1;
        bus.data_sram_wr    = 1'b1;
        bus.data_sram_size  = 2'd0;
        bus.data_sram_wstrb = 4'h4;
        bus.data_sram_wdata = 32'h00AB_0000;
        bus.data_sram_addr  = 32'h8000_0002;
        #1;
        exp = 9'b010000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL bw_accept got=%b want=%b", ctl, exp); end
        tick;
        bus.data_sram_req = 1'b0;
        bus.data_sram_wr  = 1'b0;
        bus.awready       = 1'b1;
        #1;
        exp = 9'b000011000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL bw_p1 got=%b want=%b", ctl, exp); end
        vectors++;
        if ({bus.awaddr, bus.awsize, bus.wstrb, bus.wdata} !== {32'h8000_0002, 3'd0, 4'h4, 32'h00AB_0000})
            begin miscompares++; $display("FAIL bw_fields got=%h/%0d/%h/%h want=80000002/0/4/00ab0000", bus.awaddr, bus.awsize, bus.wstrb, bus.wdata); end
        tick;
        bus.awready = 1'b0;
        #1;
        exp = 9'b000001000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL bw_p2 got=%b want=%b", ctl, exp); end
        tick;
        bus.wready = 1'b1;
        #1;
        exp = 9'b000001000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL bw_p3 got=%b want=%b", ctl, exp); end
        tick;
        bus.wready = 1'b0;
        #1;
        exp = 9'b000000100; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL bw_p4 got=%b want=%b", ctl, exp); end
        tick;
        bus.bvalid = 1'b1;
        #1;
        exp = 9'b000000101; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL bw_p5 got=%b want=%b", ctl, exp); end
        tick;
        bus.bvalid = 1'b0;
        #1;
        exp = 9'b000000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL bw_idle got=%b want=%b", ctl, exp); end
    endtask

    task automatic test_write_same_cycle;
        bus.awready         = 1'b1;
        bus.wready          = 1'b1;
        bus.data_sram_req   = 1'b1;
        bus.data_sram_wr    = 1'b1;
        bus.data_sram_size  = 2'd2;
        bus.data_sram_wstrb = 4'hF;
        bus.data_sram_wdata = 32'hDEAD_BEEF;
        bus.data_sram_addr  = 32'h8000_0010;
        #1;
        exp = 9'b010000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ww_accept got=%b want=%b", ctl, exp); end
        tick;
        bus.data_sram_req = 1'b0;
        bus.data_sram_wr  = 1'b0;
        #1;
        exp = 9'b000011000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ww_p1 got=%b want=%b", ctl, exp); end
        vectors++;
        if ({bus.awsize, bus.wdata} !== {3'd2, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL ww_fields got=%0d/%h want=2/deadbeef", bus.awsize, bus.wdata); end
        tick;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b1;
        #1;
        exp = 9'b000000101; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ww_b got=%b want=%b", ctl, exp); end
        tick;
        bus.bvalid = 1'b0;
        #1;
        exp = 9'b000000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL ww_idle got=%b want=%b", ctl, exp); end
    endtask

    task automatic test_ar_stall;
        bus.arready        = 1'b0;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'hBFC0_0010;
        #1;
        exp = 9'b100000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL stall_accept got=%b want=%b", ctl, exp); end
        for (int i = 0; i < 5; i++) begin
            tick;
            #1;
            vectors++;
            if ({ctl, bus.araddr} !== {9'b001000000, 32'hBFC0_0010}) begin miscompares++; $display("FAIL stall_hold%0d got=%b/%h want=001000000/bfc00010", i, ctl, bus.araddr); end
        end
        tick;
        bus.arready = 1'b1;
        #1;
        exp = 9'b001000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL stall_ar_hs got=%b want=%b", ctl, exp); end
        tick;
        #1;
        exp = 9'b000100000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL stall_r_wait got=%b want=%b", ctl, exp); end
        tick;
        bus.rvalid        = 1'b1;
        bus.rdata         = 32'h1234_5678;
        bus.inst_sram_req = 1'b0;
        #1;
        vectors++;
        if ({ctl, bus.inst_sram_rdata} !== {9'b000100010, 32'h1234_5678}) begin miscompares++; $display("FAIL stall_data_ok got=%b/%h want=000100010/12345678", ctl, bus.inst_sram_rdata); end
        tick;
        bus.rvalid = 1'b0;
        #1;
        exp = 9'b000000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL stall_idle got=%b want=%b", ctl, exp); end
    endtask

    task automatic test_reset_mid;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'hBFC0_0020;
        #1;
        tick;
        bus.inst_sram_req = 1'b0;
        #1;
        exp = 9'b001000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rmid_ar got=%b want=%b", ctl, exp); end
        tick;
        exp = 9'b000100000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rmid_in_r got=%b want=%b", ctl, exp); end
        bus.rvalid         = 1'b1;
        bus.rdata          = 32'hCAFE_0000;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'hBFC0_0000;
        reset              = 1'b1;
        #1;
        vectors++;
        if ({ctl, bus.araddr} !== {9'b000000000, 32'd0}) begin miscompares++; $display("FAIL rmid_abort got=%b/%h want=000000000/00000000", ctl, bus.araddr); end
        tick;
        reset      = 1'b0;
        bus.rvalid = 1'b0;
        #1;
        exp = 9'b100000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rmid_fresh_accept got=%b want=%b", ctl, exp); end
        tick;
        bus.inst_sram_req = 1'b0;
        #1;
        vectors++;
        if ({ctl, bus.araddr} !== {9'b001000000, 32'hBFC0_0000}) begin miscompares++; $display("FAIL rmid_fresh_ar got=%b/%h want=001000000/bfc00000", ctl, bus.araddr); end
        tick;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0F0F_0F0F;
        #1;
        vectors++;
        if ({ctl, bus.inst_sram_rdata} !== {9'b000100010, 32'h0F0F_0F0F}) begin miscompares++; $display("FAIL rmid_fresh_ok got=%b/%h want=000100010/0f0f0f0f", ctl, bus.inst_sram_rdata); end
        tick;
        bus.rvalid = 1'b0;
        #1;
        exp = 9'b000000000; vectors++;
        if (ctl !== exp) begin miscompares++; $display("FAIL rmid_idle got=%b want=%b", ctl, exp); end
    endtask

    initial begin
        vectors             = 0;
        miscompares         = 0;
        reset               = 1'b1;
        bus.inst_sram_req   = 1'b0;
        bus.inst_sram_addr  = 32'd0;
        bus.data_sram_req   = 1'b0;
        bus.data_sram_wr    = 1'b0;
        bus.data_sram_size  = 2'd0;
        bus.data_sram_wstrb = 4'd0;
        bus.data_sram_addr  = 32'd0;
        bus.data_sram_wdata = 32'd0;
        bus.arready         = 1'b1;
        bus.rdata           = 32'd0;
        bus.rvalid          = 1'b0;
        bus.awready         = 1'b0;
        bus.wready          = 1'b0;
        bus.bvalid          = 1'b0;

        test_reset;
        tick;
        test_inst_read;
        tick;
        test_priority;
        tick;
        test_byte_write;
        tick;
        test_write_same_cycle;
        tick;
        test_ar_stall;
        tick;
        test_reset_mid;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Downstream of mycpu_sram: converts the CPU's SRAM-like instruction and data ports into one AXI master with a single outstanding transaction. Arbitrates between the two ports and returns addr_ok/data_ok handshakes to the CPU.

Parameters:
none (32-bit address/data, ID fixed to 0; len/burst/lock/cache/prot constants are driven in the top wrapper)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
inst_sram_req  in  1  instruction read request (inst port is read-only)
inst_sram_addr  in  32  instruction address
inst_sram_addr_ok  out  1  inst request accepted this cycle
inst_sram_addr_ok_addr  out  32  address accepted with inst_sram_addr_ok
inst_sram_data_ok  out  1  inst read data valid, 1-cycle pulse
inst_sram_rdata  out  32  inst read data
data_sram_req  in  1  data request
data_sram_wr  in  1  1 = write, 0 = read
data_sram_size  in  2  0 = byte, 1 = half, 2 = word
data_sram_wstrb  in  4  byte enables
data_sram_addr  in  32  data address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  data request accepted this cycle
data_sram_data_ok  out  1  read data valid / write done, 1-cycle pulse
data_sram_rdata  out  32  data read data
araddr  out  32  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  AXI read data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobe
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B. On reset, state = IDLE, owner = inst, and all valid/ready/addr_ok/data_ok outputs = 0. Latched registers reset to 0.
- Acceptance in IDLE only. data_sram_addr_ok = IDLE & data_sram_req. inst_sram_addr_ok = IDLE & inst_sram_req & ~data_sram_req, so data has fixed priority. inst_sram_addr_ok_addr = inst_sram_addr (combinational). On accept, latch owner, addr, size (zero-extended to 3 bits for ar/awsize), wstrb, and wdata. Then go to RD_AR (read) or WR_AW_W (write).
- Read path:
  - RD_AR: arvalid = 1. On arready, go to RD_R.
  - RD_R: rready = 1. On rvalid, pulse the owner's data_ok for that cycle, with owner rdata = rdata (combinational pass-through), and return to IDLE.
  - Minimum latency: request at cycle N, arvalid at N+1, data_ok at N+2.
- Write path:
  - WR_AW_W: awvalid and wvalid are raised together. Each one drops after its own handshake, tracked by aw_done/w_done flags; handshakes may occur in either order or in the same cycle. Go to WR_B once both are done.
  - WR_B: bready = 1. On bvalid, pulse data_sram_data_ok and return to IDLE. bresp and rresp are ignored.
- Only one transaction is outstanding at any time. Requests are not accepted again until the cycle after data_ok. Held requests keep waiting without loss.
- Reset asserted mid-transaction forces IDLE immediately and drops all valids. No data_ok is issued for the aborted transfer.

Test Plan:
- Inst read 0xBFC00000, arready=1, rvalid the next cycle with 0x3C1D0001 → inst_sram_addr_ok at N, arvalid at N+1, inst_sram_data_ok with rdata 0x3C1D0001 at N+2.
- inst_req and data read both asserted at 0x80001000 → data accepted first. inst_sram_addr_ok only rises in IDLE after data_sram_data_ok; inst_sram_addr_ok_addr equals the inst address.
- Byte write size=0, wstrb=0x4, wdata=0x00AB0000, with awready at +1 and wready at +3 → awvalid drops after +1, wvalid held until +3, bready after that. One data_ok pulse on bvalid; awsize=0.
- arready held low for 5 cycles → arvalid and araddr stay stable, no new addr_ok pulses, data_ok only after the R handshake.
- Reset asserted while in RD_R → state IDLE and all outputs 0 immediately. After release, a fresh inst read completes normally.
